// File: rtl/unidade_controle_pkg.sv
// Shared constants for the control unit: opcodes, FSM states, bus codes and helpers.
// Pure declarations, no latency or backpressure of its own.
// Legality rules live here so decoder and any future users agree on them.
package controle_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MOV   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_LOAD  = 4'd4;
    localparam logic [3:0] OP_STORE = 4'd5;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_EXEC,
        S_RADDR,
        S_RWAIT,
        S_RLATCH,
        S_WADDR,
        S_WWAIT,
        S_WCLR,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] BB_NONE = 4'd0;
    localparam logic [3:0] BB_MDR  = 4'd1;
    localparam logic [3:0] BB_SP   = 4'd4;
    localparam logic [3:0] BB_LV   = 4'd5;
    localparam logic [3:0] BB_CPP  = 4'd6;
    localparam logic [3:0] BB_TOS  = 4'd7;
    localparam logic [3:0] BB_OPC  = 4'd8;

    localparam int CB_MAR = 0;
    localparam int CB_MDR = 1;
    localparam int CB_PC  = 2;
    localparam int CB_MBR = 3;
    localparam int CB_SP  = 4;
    localparam int CB_LV  = 5;
    localparam int CB_CPP = 6;
    localparam int CB_TOS = 7;
    localparam int CB_OPC = 8;
    localparam int CB_H   = 9;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b001;
    localparam logic [2:0] ALU_SUB    = 3'b010;

    localparam logic [1:0] RAM_IDLE = 2'b00;
    localparam logic [1:0] RAM_RD   = 2'b01;
    localparam logic [1:0] RAM_WR   = 2'b10;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] dst;
        logic [3:0] src;
        logic [3:0] addr;
    } instr_t;

    function automatic logic src_ok(input logic [3:0] s);
        return (s == BB_MDR) || ((s >= BB_SP) && (s <= BB_OPC));
    endfunction

    function automatic logic dst_ok(input logic [3:0] d);
        return (d >= 4'(CB_SP)) && (d <= 4'(CB_H));
    endfunction

    function automatic logic is_legal(input instr_t i);
        logic ok;
        ok = 1'b0;
        case (i.opcode)
            OP_NOP:                 ok = 1'b1;
            OP_MOV, OP_ADD, OP_SUB: ok = src_ok(i.src) && dst_ok(i.dst);
            OP_LOAD:                ok = dst_ok(i.dst);
            OP_STORE:               ok = src_ok(i.src);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Instruction handshake plus per-cycle bank/ALU/RAM control bundle of the control unit.
// Wiring only; perf counters appear when UNIDADE_CONTROLE_PERF_EN is defined.
// instr_valid/instr_ready handshake; all other signals are sequencer outputs.
interface unidade_controle_if;

    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  bbus_sig;
    logic [9:0]  cbus_sig;
    logic [3:0]  ram_addr;
    logic [1:0]  ram_wr_enable;
    logic [2:0]  alu_op;
    logic        done;
    logic        err;

`ifdef UNIDADE_CONTROLE_PERF_EN
    logic [15:0] retired_cnt;
    logic [7:0]  err_cnt;

    modport master (
        output instr, instr_valid,
        input  instr_ready, bbus_sig, cbus_sig, ram_addr, ram_wr_enable,
        input  alu_op, done, err, retired_cnt, err_cnt
    );
    modport slave (
        input  instr, instr_valid,
        output instr_ready, bbus_sig, cbus_sig, ram_addr, ram_wr_enable,
        output alu_op, done, err, retired_cnt, err_cnt
    );
`else
    modport master (
        output instr, instr_valid,
        input  instr_ready, bbus_sig, cbus_sig, ram_addr, ram_wr_enable,
        input  alu_op, done, err
    );
    modport slave (
        input  instr, instr_valid,
        output instr_ready, bbus_sig, cbus_sig, ram_addr, ram_wr_enable,
        output alu_op, done, err
    );
`endif

endinterface

// File: rtl/unidade_controle_contador_espera.sv
// Loadable 4-bit down-counter with zero flag, paces the RAM wait states.
// Load/decrement take effect on the next edge; zero is combinational from the count.
// No backpressure; decrement stops at zero.
module contador_espera (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle sequencer expanding one instruction into bank strobes, ALU select and RAM commands.
// Done after 1 (NOP/illegal), 2 (MOV/ADD/SUB) or 4+RAM_LAT (LOAD/STORE) cycles from acceptance.
// instr_ready only in IDLE; optional perf counters under UNIDADE_CONTROLE_PERF_EN.
module unidade_controle
    import controle_pkg::*;
#(
    parameter int unsigned RAM_LAT = 1
) (
    input  logic               clock,
    input  logic               reset,
    unidade_controle_if.slave  bus
);

    localparam logic [3:0] WAIT_LOAD = (RAM_LAT == 0) ? 4'd0 : 4'(RAM_LAT - 1);

    state_t state, state_nxt;
    instr_t iq;
    instr_t instr_in;

    logic       rdy;
    logic [3:0] bb;
    logic [9:0] cb;
    logic [3:0] addr;
    logic [1:0] ram;
    logic [2:0] alu;
    logic       dn;
    logic       er;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;

    assign instr_in = instr_t'(bus.instr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_INIT;
            iq    <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && bus.instr_valid) begin
                iq <= instr_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        bb        = BB_NONE;
        cb        = '0;
        addr      = 4'd0;
        ram       = RAM_IDLE;
        alu       = ALU_PASS_B;
        dn        = 1'b0;
        er        = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            S_INIT: begin
                cb[CB_PC] = 1'b1;
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                rdy = 1'b1;
                if (bus.instr_valid) begin
                    if (!is_legal(instr_in))               state_nxt = S_ERR;
                    else if (instr_in.opcode == OP_NOP)    state_nxt = S_DONE;
                    else if (instr_in.opcode == OP_LOAD)   state_nxt = S_RADDR;
                    else                                   state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                bb = (iq.opcode == OP_LOAD) ? BB_MDR : iq.src;
                case (iq.opcode)
                    OP_ADD:  alu = ALU_ADD;
                    OP_SUB:  alu = ALU_SUB;
                    default: alu = ALU_PASS_B;
                endcase
                // STORE routes the operand into MBR for the write rather than a bank register
                if (iq.opcode == OP_STORE) begin
                    cb[CB_MBR] = 1'b1;
                    state_nxt  = S_WADDR;
                end else begin
                    cb[iq.dst] = 1'b1;
                    state_nxt  = S_DONE;
                end
            end
            S_RADDR: begin
                cb[CB_MAR] = 1'b1;
                cb[CB_PC]  = 1'b1;
                addr       = iq.addr;
                ram        = RAM_RD;
                if (RAM_LAT == 0) begin
                    state_nxt = S_RLATCH;
                end else begin
                    cnt_load  = 1'b1;
                    state_nxt = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (cnt_zero) state_nxt = S_RLATCH;
                else          cnt_dec   = 1'b1;
            end
            S_RLATCH: begin
                cb[CB_MDR] = 1'b1;
                cb[CB_PC]  = 1'b1;
                state_nxt  = S_EXEC;
            end
            S_WADDR: begin
                cb[CB_MAR] = 1'b1;
                cb[CB_PC]  = 1'b1;
                addr       = iq.addr;
                ram        = RAM_WR;
                if (RAM_LAT == 0) begin
                    state_nxt = S_WCLR;
                end else begin
                    cnt_load  = 1'b1;
                    state_nxt = S_WWAIT;
                end
            end
            S_WWAIT: begin
                if (cnt_zero) state_nxt = S_WCLR;
                else          cnt_dec   = 1'b1;
            end
            S_WCLR: begin
                cb[CB_PC] = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                dn        = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                dn        = 1'b1;
                er        = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    contador_espera u_espera (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Reset must silence the INIT strobe immediately, so outputs are gated by reset itself
    assign bus.instr_ready   = rdy & ~reset;
    assign bus.bbus_sig      = reset ? 4'd0  : bb;
    assign bus.cbus_sig      = reset ? 10'd0 : cb;
    assign bus.ram_addr      = reset ? 4'd0  : addr;
    assign bus.ram_wr_enable = reset ? RAM_IDLE : ram;
    assign bus.alu_op        = reset ? ALU_PASS_B : alu;
    assign bus.done          = dn & ~reset;
    assign bus.err           = er & ~reset;

`ifdef UNIDADE_CONTROLE_PERF_EN
    logic [15:0] retired_q;
    logic [7:0]  err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_q <= 16'd0;
            err_q     <= 8'd0;
        end else begin
            if (state == S_DONE) retired_q <= retired_q + 16'd1;
            if ((state == S_ERR) && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
        end
    end

    assign bus.retired_cnt = retired_q;
    assign bus.err_cnt     = err_q;
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: directed instructions, trace-based reference model, per-cycle compare.
module tb_unidade_controle;

    localparam int LAT = 2;

    typedef struct packed {
        logic       rdy;
        logic [3:0] bb;
        logic [9:0] cb;
        logic [3:0] addr;
        logic [1:0] ram;
        logic [2:0] alu;
        logic       done;
        logic       err;
    } out_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    unidade_controle_if bus ();

    unidade_controle #(.RAM_LAT(LAT)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    out_t dut_out;
    assign dut_out = {bus.instr_ready, bus.bbus_sig, bus.cbus_sig, bus.ram_addr,
                      bus.ram_wr_enable, bus.alu_op, bus.done, bus.err};

    function automatic out_t mk(input logic r, input logic [3:0] b, input logic [9:0] c,
                                input logic [3:0] a, input logic [1:0] m, input logic [2:0] al,
                                input logic d, input logic e);
        out_t o;
        o = {r, b, c, a, m, al, d, e};
        return o;
    endfunction

    // Reference model: each accepted instruction becomes the list of output words it must produce
    out_t        q[$];
    out_t        cur     = 26'h0;
    logic        in_init = 1'b1;
    logic        m_idle  = 1'b0;
    logic [15:0] m_ret   = 16'd0;
    logic [7:0]  m_err   = 8'd0;

    task automatic model_push(input logic [15:0] ins);
        logic [3:0] op, d, s, a;
        logic       legal;
        out_t       done_w;
        op = ins[15:12]; d = ins[11:8]; s = ins[7:4]; a = ins[3:0];
        done_w = mk(0, 0, 0, 0, 0, 0, 1, 0);
        legal = (op == 0)
             || ((op inside {4'd1, 4'd2, 4'd3}) && (s inside {4'd1, [4'd4:4'd8]}) && (d inside {[4'd4:4'd9]}))
             || ((op == 4) && (d inside {[4'd4:4'd9]}))
             || ((op == 5) && (s inside {4'd1, [4'd4:4'd8]}));
        if (!legal) begin
            q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
        end else begin
            case (op)
                4'd1: q.push_back(mk(0, s, 10'b1 << d, 0, 0, 3'd0, 0, 0));
                4'd2: q.push_back(mk(0, s, 10'b1 << d, 0, 0, 3'd1, 0, 0));
                4'd3: q.push_back(mk(0, s, 10'b1 << d, 0, 0, 3'd2, 0, 0));
                4'd4: begin
                    q.push_back(mk(0, 0, 10'h005, a, 2'b01, 0, 0, 0));
                    for (int i = 0; i < LAT; i++) q.push_back(26'h0);
                    q.push_back(mk(0, 0, 10'h006, 0, 0, 0, 0, 0));
                    q.push_back(mk(0, 4'd1, 10'b1 << d, 0, 0, 0, 0, 0));
                end
                4'd5: begin
                    q.push_back(mk(0, s, 10'h008, 0, 0, 0, 0, 0));
                    q.push_back(mk(0, 0, 10'h005, a, 2'b10, 0, 0, 0));
                    for (int i = 0; i < LAT; i++) q.push_back(26'h0);
                    q.push_back(mk(0, 0, 10'h004, 0, 0, 0, 0, 0));
                end
                default: ;
            endcase
            q.push_back(done_w);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            in_init = 1'b1;
            m_idle  = 1'b0;
            cur     = mk(0, 0, 10'h004, 0, 0, 0, 0, 0);
            m_ret   = 16'd0;
            m_err   = 8'd0;
        end else begin
            if (cur.done && !cur.err) m_ret = m_ret + 16'd1;
            if (cur.done && cur.err && (m_err != 8'hFF)) m_err = m_err + 8'd1;
            if (in_init) begin
                in_init = 1'b0;
                cur     = mk(1, 0, 0, 0, 0, 0, 0, 0);
                m_idle  = 1'b1;
            end else if (m_idle && bus.instr_valid) begin
                model_push(bus.instr);
                cur    = q.pop_front();
                m_idle = 1'b0;
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur    = mk(1, 0, 0, 0, 0, 0, 0, 0);
                m_idle = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        out_t e;
        e = reset ? 26'h0 : cur;
        tests++;
        if (dut_out !== e) begin
            fails++;
            $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, dut_out, e);
        end
`ifdef UNIDADE_CONTROLE_PERF_EN
        tests++;
        if ((bus.retired_cnt !== m_ret) || (bus.err_cnt !== m_err)) begin
            fails++;
            $display("FAIL perf_compare t=%0t actual=%h/%h required=%h/%h", $time,
                     bus.retired_cnt, bus.err_cnt, m_ret, m_err);
        end
`endif
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    out_t tr [1:15];

    function automatic int lat();
        for (int k = 1; k <= 15; k++) if (tr[k].done) return k;
        return 0;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clock);
        while ((bus.instr_ready !== 1'b1) && (n < 50)) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [15:0] ins);
        wait_ready();
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            if (k == 1) begin
                bus.instr_valid = 1'b0;
                bus.instr       = ~ins;
            end
            tr[k] = dut_out;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bus.instr       = 16'h0;
        bus.instr_valid = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_outputs", dut_out, 32'h0);
        #3 reset = 1'b0;
        #1;
        check("init_cb", bus.cbus_sig, 10'h004);
        check("init_ram", bus.ram_wr_enable, 2'b00);
        check("init_rdy", bus.instr_ready, 1'b0);
        @(negedge clock);
        check("idle_rdy", bus.instr_ready, 1'b1);
        check("idle_cb", bus.cbus_sig, 10'h000);

        issue(16'h1740);
        check("mov_c1_bb", tr[1].bb, 4'd4);
        check("mov_c1_alu", tr[1].alu, 3'b000);
        check("mov_c1_cb", tr[1].cb, 10'h080);
        check("mov_lat", lat(), 2);
        check("mov_err", tr[2].err, 1'b0);

        issue(16'h2956);
        check("add_c1", {tr[1].bb, tr[1].alu, tr[1].cb}, {4'd5, 3'b001, 10'h200});
        issue(16'h3681);
        check("sub_c1", {tr[1].bb, tr[1].alu, tr[1].cb}, {4'd8, 3'b010, 10'h040});

        issue(16'h4503);
        check("ld_raddr", {tr[1].cb, tr[1].addr, tr[1].ram}, {10'h005, 4'd3, 2'b01});
        check("ld_wait1", tr[2], 32'h0);
        check("ld_wait2", tr[3], 32'h0);
        check("ld_rlatch", {tr[4].cb, tr[4].ram}, {10'h006, 2'b00});
        check("ld_exec", {tr[5].bb, tr[5].cb}, {4'd1, 10'h020});
        check("ld_lat", lat(), 6);

        issue(16'h5089);
        check("st_exec", {tr[1].bb, tr[1].cb}, {4'd8, 10'h008});
        check("st_waddr", {tr[2].cb, tr[2].addr, tr[2].ram}, {10'h005, 4'd9, 2'b10});
        check("st_wclr", {tr[5].cb, tr[5].ram}, {10'h004, 2'b00});
        check("st_lat", lat(), 6);

        issue(16'h0000);
        check("nop_done", {tr[1].done, tr[1].err}, 2'b10);

        issue(16'h7000);
        check("ill_op", {tr[1].done, tr[1].err, tr[1].cb}, {2'b11, 10'h000});
        issue(16'h1240);
        check("ill_dst", {tr[1].done, tr[1].err, tr[1].cb}, {2'b11, 10'h000});
        issue(16'h5029);
        check("ill_src", {tr[1].done, tr[1].err}, 2'b11);
        issue(16'h4303);
        check("ill_ld_dst", lat(), 1);

        // valid held high across completion: a second copy must be accepted only from IDLE
        wait_ready();
        bus.instr       = 16'h2956;
        bus.instr_valid = 1'b1;
        repeat (9) @(negedge clock);
        bus.instr_valid = 1'b0;

        // reset during the LOAD wait state
        wait_ready();
        bus.instr       = 16'h4503;
        bus.instr_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.instr_valid = 1'b0;
        @(negedge clock);
        check("abort_pre_ram", bus.ram_wr_enable, 2'b00);
        #1 reset = 1'b1;
        #1;
        check("abort_zero", dut_out, 32'h0);
        @(negedge clock);
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        check("reinit_cb", {bus.cbus_sig, bus.ram_wr_enable, bus.instr_ready}, {10'h004, 2'b00, 1'b0});
        @(negedge clock);
        check("reinit_idle", {bus.instr_ready, bus.done}, 2'b10);

        issue(16'h1740);
        issue(16'h2956);
        issue(16'h0000);
        issue(16'h7000);
        @(negedge clock);
`ifdef UNIDADE_CONTROLE_PERF_EN
        check("perf_retired", bus.retired_cnt, 16'd3);
        check("perf_err", bus.err_cnt, 8'd1);
`endif

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
